// File: rtl/mipi_dphy_pkg.sv
// Shared types and constants for the D-PHY HS transmit path.
// Holds the FSM state type, the fixed sync byte and the counter-width rule.
package mipi_dphy_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HSZERO,
      SYNC,
      DATA,
      TRAIL
   } hs_tx_state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hB8;

   // The counter must reach the longest phase: one word, the sync byte, HS-0 or the trailer.
   function automatic int hs_cnt_w(input int dw2, input int hz, input int tr);
      int m;
      m = 4;
      if (dw2 > m) m = dw2;
      if (hz > m)  m = hz;
      if (tr > m)  m = tr;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/hs_lane_shifter.sv
// One lane: loads a word or the sync byte and emits 2 bits/cycle, LSB first, on registered outputs.
// Bits appear the cycle after a load; it never stalls, and the trailer drives the inverse of the last bit.
module hs_lane_shifter
   import mipi_dphy_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              TxDDRClk,
   input  logic              TxRst,
   input  logic              ld_sync,
   input  logic              ld_data,
   input  logic              shift,
   input  logic              trail,
   input  logic [DATA_W-1:0] data,
   output logic              ser_b1,
   output logic              ser_b2
);

   localparam int SW = (DATA_W > 8) ? DATA_W : 8;

   logic [SW-1:0] sh;
   logic          last_bit;

   always_ff @(posedge TxDDRClk) begin
      if (!TxRst) begin
         sh       <= '0;
         last_bit <= 1'b0;
         ser_b1   <= 1'b0;
         ser_b2   <= 1'b0;
      end else if (ld_data) begin
         sh       <= SW'(data) >> 2;
         ser_b1   <= data[0];
         ser_b2   <= data[1];
         last_bit <= data[1];
      end else if (ld_sync) begin
         sh       <= SW'(SYNC_BYTE) >> 2;
         ser_b1   <= SYNC_BYTE[0];
         ser_b2   <= SYNC_BYTE[1];
         last_bit <= SYNC_BYTE[1];
      end else if (shift) begin
         sh       <= sh >> 2;
         ser_b1   <= sh[0];
         ser_b2   <= sh[1];
         last_bit <= sh[1];
      end else if (trail) begin
         ser_b1   <= ~last_bit;
         ser_b2   <= ~last_bit;
      end else begin
         ser_b1   <= 1'b0;
         ser_b2   <= 1'b0;
      end
   end

endmodule

// File: rtl/hs_ddr_serializer.sv
// Multi-lane HS burst serializer: HS-0, sync byte, words, trailer; 2 bits per lane per TxDDRClk cycle.
// Latency: SOT one cycle after request; ready only at word boundaries, and no transfer there ends the burst.
module hs_ddr_serializer
   import mipi_dphy_pkg::*;
#(
   parameter int LANES       = 1,
   parameter int DATA_W      = 8,
   parameter int HS_ZERO_CYC = 4,
   parameter int TRAIL_CYC   = 4
) (
   input  logic                    TxDDRClk,
   input  logic                    TxRst,
   input  logic                    TxRequestHS,
   input  logic [LANES*DATA_W-1:0] TxDataHS,
   input  logic                    TxValidHS,
   output logic                    TxReadyHS,
   output logic [LANES-1:0]        ser_b1,
   output logic [LANES-1:0]        ser_b2,
   output logic                    SOT,
   output logic                    busy
);

   localparam int W2 = DATA_W / 2;
   localparam int CW = hs_cnt_w(W2, HS_ZERO_CYC, TRAIL_CYC);

   localparam logic [CW-1:0] HZ_LAST = CW'(HS_ZERO_CYC - 1);
   localparam logic [CW-1:0] SY_LAST = CW'(3);
   localparam logic [CW-1:0] WD_LAST = CW'(W2 - 1);
   localparam logic [CW-1:0] TR_LAST = CW'(TRAIL_CYC - 1);

   hs_tx_state_t  state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          at_bnd, xfer, ld_sync, shift, trail;

   assign at_bnd    = (state == SYNC && cnt == SY_LAST) || (state == DATA && cnt == WD_LAST);
   assign TxReadyHS = at_bnd & TxRequestHS;
   assign xfer      = TxReadyHS & TxValidHS;
   assign busy      = (state != IDLE);
   assign ld_sync   = (state == HSZERO) && (cnt == HZ_LAST);
   assign shift     = (state == SYNC || state == DATA) && !at_bnd;
   assign trail     = (state_nxt == TRAIL);

   always_ff @(posedge TxDDRClk) begin
      if (!TxRst) begin
         state <= IDLE;
         cnt   <= '0;
         SOT   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         SOT   <= (state_nxt != IDLE);
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CW'(1);
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (TxRequestHS) state_nxt = HSZERO;
         end
         HSZERO: begin
            if (cnt == HZ_LAST) begin
               state_nxt = SYNC;
               cnt_nxt   = '0;
            end
         end
         SYNC, DATA: begin
            // Each boundary either loads the next word or closes the burst.
            if (at_bnd) begin
               state_nxt = xfer ? DATA : TRAIL;
               cnt_nxt   = '0;
            end
         end
         TRAIL: begin
            if (cnt == TR_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   for (genvar n = 0; n < LANES; n++) begin : g_lane
      hs_lane_shifter #(.DATA_W(DATA_W)) u_lane (
         .TxDDRClk (TxDDRClk),
         .TxRst    (TxRst),
         .ld_sync  (ld_sync),
         .ld_data  (xfer),
         .shift    (shift),
         .trail    (trail),
         .data     (TxDataHS[n*DATA_W +: DATA_W]),
         .ser_b1   (ser_b1[n]),
         .ser_b2   (ser_b2[n])
      );
   end

endmodule

// File: tb/tb_hs_ddr_serializer.sv
// Bench for hs_ddr_serializer: two lanes, randomized bursts checked against a bit-stream model.
module tb_hs_ddr_serializer;

   localparam int LANES = 2;
   localparam int DW    = 8;
   localparam int HZ    = 4;
   localparam int TC    = 4;
   localparam int DT    = LANES * DW;

   typedef struct packed {
      logic             sot;
      logic             busy;
      logic             rdy;
      logic [LANES-1:0] b1;
      logic [LANES-1:0] b2;
   } smp_t;

   logic             clk = 1'b0;
   logic             TxRst = 1'b0;
   logic             TxRequestHS = 1'b0;
   logic [DT-1:0]    TxDataHS = '0;
   logic             TxValidHS = 1'b0;
   logic             TxReadyHS;
   logic [LANES-1:0] ser_b1, ser_b2;
   logic             SOT, busy;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic [DT-1:0] wq[$];
   smp_t obs_q[$];
   smp_t exp_q[$];
   logic [7:0] sync_b = 8'hB8;

   always #5 clk = ~clk;

   hs_ddr_serializer #(
      .LANES(LANES), .DATA_W(DW), .HS_ZERO_CYC(HZ), .TRAIL_CYC(TC)
   ) dut (
      .TxDDRClk    (clk),
      .TxRst       (TxRst),
      .TxRequestHS (TxRequestHS),
      .TxDataHS    (TxDataHS),
      .TxValidHS   (TxValidHS),
      .TxReadyHS   (TxReadyHS),
      .ser_b1      (ser_b1),
      .ser_b2      (ser_b2),
      .SOT         (SOT),
      .busy        (busy)
   );

   // Bit s of a lane's wire stream: 8 sync bits, then each queued word LSB first.
   function automatic logic exp_bit(input int l, input int s);
      int k;
      logic [DT-1:0] w;
      if (s < 8) return sync_b[s];
      k = s - 8;
      w = wq[k / DW];
      return w[l*DW + (k % DW)];
   endfunction

   // Drives one burst from its IDLE request cycle and records observed vs modelled samples.
   // mode 0: ends by valid=0 at the boundary; mode 1: request drops mid last word.
   task automatic run_burst(input int n, input int mode, input int abort_c, input bit keep);
      int w2, bn, drop_c, s;
      logic req;
      smp_t e;
      logic [LANES-1:0] lastv;
      w2 = DW / 2;
      bn = HZ + 4 + n * w2;
      drop_c = (n > 0) ? bn - 1 : HZ + 2;
      obs_q.delete();
      exp_q.delete();
      for (int l = 0; l < LANES; l++) lastv[l] = exp_bit(l, 8 + n * DW - 1);
      for (int c = 0; c <= bn + TC; c++) begin
         if (mode == 1) req = (c < drop_c);
         else req = (c <= bn) ? 1'b1 : (keep ? 1'b1 : 1'($urandom_range(0, 1)));
         TxRequestHS = req;
         TxRst       = (c == abort_c) ? 1'b0 : 1'b1;
         TxValidHS   = 1'($urandom_range(0, 1));
         TxDataHS    = DT'($urandom);
         if (c >= HZ + 4 && (c - HZ - 4) % w2 == 0) begin
            if ((c - HZ - 4) / w2 < n) begin
               TxValidHS = 1'b1;
               TxDataHS  = wq[(c - HZ - 4) / w2];
            end else begin
               TxValidHS = (mode == 1);
            end
         end
         e = '0;
         if (c >= 1) begin
            e.sot  = 1'b1;
            e.busy = 1'b1;
         end
         if (c > HZ && c <= bn) begin
            s = 2 * (c - HZ - 1);
            for (int l = 0; l < LANES; l++) begin
               e.b1[l] = exp_bit(l, s);
               e.b2[l] = exp_bit(l, s + 1);
            end
            e.rdy = req && (c >= HZ + 4) && ((c - HZ - 4) % w2 == 0);
         end else if (c > bn) begin
            e.b1 = ~lastv;
            e.b2 = ~lastv;
         end
         @(negedge clk);
         obs_q.push_back({SOT, busy, TxReadyHS, ser_b1, ser_b2});
         exp_q.push_back(e);
         @(posedge clk);
         #1;
         if (c == abort_c) begin
            TxRst = 1'b1;
            TxRequestHS = 1'b0;
            TxValidHS = 1'b0;
            repeat (3) begin
               @(negedge clk);
               obs_q.push_back({SOT, busy, TxReadyHS, ser_b1, ser_b2});
               exp_q.push_back('0);
               @(posedge clk);
               #1;
            end
            return;
         end
      end
   endtask

   task automatic idle_cycles(input int k);
      TxRequestHS = 1'b0;
      TxValidHS   = 1'b0;
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      smp_t o;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         TxRequestHS = 1'b1;
         TxValidHS   = 1'($urandom_range(0, 1));
         TxDataHS    = DT'($urandom);
         @(negedge clk);
         o = {SOT, busy, TxReadyHS, ser_b1, ser_b2};
         n_cmp++;
         if (o !== '0) begin
            n_bad++;
            $display("FAIL reset cyc%0d got sot/busy/rdy/b1/b2=%b want 0", i, o);
         end
      end
      @(posedge clk);
      #1;
      TxRst = 1'b1;
      TxRequestHS = 1'b0;
      TxValidHS = 1'b0;
   endtask

   task automatic test_single_word;
      wq.delete();
      wq.push_back({8'($urandom), 8'hA5});
      run_burst(1, 0, -1, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL single_word cyc%0d got %b want %b", i, obs_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (obs_q[1].sot !== 1'b1) begin
         n_bad++;
         $display("FAIL single_sot_rise got %b want 1", obs_q[1].sot);
      end
      n_cmp++;
      if ({obs_q[HZ+5].b1[0], obs_q[HZ+5].b2[0]} !== 2'b10) begin
         n_bad++;
         $display("FAIL single_first_pair got %b%b want 10", obs_q[HZ+5].b1[0], obs_q[HZ+5].b2[0]);
      end
      n_cmp++;
      if ({obs_q[HZ+9].b1[0], obs_q[HZ+9].b2[0]} !== 2'b00) begin
         n_bad++;
         $display("FAIL single_trail got %b%b want 00", obs_q[HZ+9].b1[0], obs_q[HZ+9].b2[0]);
      end
      TxRequestHS = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({SOT, busy} !== 2'b00) begin
         n_bad++;
         $display("FAIL single_sot_fall got sot/busy=%b%b want 00", SOT, busy);
      end
      idle_cycles(1);
   endtask

   task automatic test_back_to_back;
      int r;
      wq.delete();
      wq.push_back({8'($urandom), 8'h00});
      wq.push_back({8'($urandom), 8'hFF});
      wq.push_back({8'($urandom), 8'h3C});
      run_burst(3, 0, -1, 0);
      r = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (obs_q[i].rdy) r++;
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL back_to_back cyc%0d got %b want %b", i, obs_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (r != 4) begin
         n_bad++;
         $display("FAIL b2b_ready_pulses got %0d want 4", r);
      end
      n_cmp++;
      if ({obs_q[HZ+17].b1[0], obs_q[HZ+17].b2[0]} !== 2'b11) begin
         n_bad++;
         $display("FAIL b2b_trail got %b%b want 11", obs_q[HZ+17].b1[0], obs_q[HZ+17].b2[0]);
      end
      idle_cycles(2);
   endtask

   task automatic test_underrun;
      for (int n = 0; n < 2; n++) begin
         wq.delete();
         wq.push_back(DT'($urandom));
         run_burst(n, 0, -1, 0);
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
               n_bad++;
               $display("FAIL underrun%0d cyc%0d got %b want %b", n, i, obs_q[i], exp_q[i]);
            end
         end
         idle_cycles(2);
      end
   endtask

   task automatic test_req_drop;
      wq.delete();
      wq.push_back(DT'($urandom));
      wq.push_back(DT'($urandom));
      run_burst(2, 1, -1, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL req_drop cyc%0d got %b want %b", i, obs_q[i], exp_q[i]);
         end
      end
      idle_cycles(2);
   endtask

   task automatic test_retrigger;
      for (int b = 0; b < 2; b++) begin
         wq.delete();
         wq.push_back(DT'($urandom));
         run_burst(1, 0, -1, (b == 0));
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
               n_bad++;
               $display("FAIL retrigger%0d cyc%0d got %b want %b", b, i, obs_q[i], exp_q[i]);
            end
         end
      end
      idle_cycles(2);
   endtask

   task automatic test_reset_mid_data;
      for (int b = 0; b < 2; b++) begin
         wq.delete();
         wq.push_back(DT'($urandom));
         wq.push_back(DT'($urandom));
         run_burst(2, 0, (b == 0) ? HZ + 6 : -1, 0);
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
               n_bad++;
               $display("FAIL reset_mid%0d cyc%0d got %b want %b", b, i, obs_q[i], exp_q[i]);
            end
         end
      end
      idle_cycles(2);
   endtask

   task automatic test_two_lanes;
      wq.delete();
      wq.push_back({8'h01, 8'h80});
      run_burst(1, 0, -1, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL two_lanes cyc%0d got %b want %b", i, obs_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if ({obs_q[HZ+9].b1, obs_q[HZ+9].b2} !== 4'b1010) begin
         n_bad++;
         $display("FAIL two_lanes_trail got b1=%b b2=%b want b1=10 b2=10", obs_q[HZ+9].b1, obs_q[HZ+9].b2);
      end
      idle_cycles(2);
   endtask

   task automatic test_random;
      int n, m;
      for (int b = 0; b < 6; b++) begin
         n = $urandom_range(0, 4);
         m = $urandom_range(0, 1);
         wq.delete();
         for (int j = 0; j < n; j++) wq.push_back(DT'($urandom));
         run_burst(n, m, -1, 0);
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
               n_bad++;
               $display("FAIL random%0d n%0d mode%0d cyc%0d got %b want %b", b, n, m, i, obs_q[i], exp_q[i]);
            end
         end
         idle_cycles(1);
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_underrun();
      test_req_drop();
      test_retrigger();
      test_reset_mid_data();
      test_two_lanes();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
